// File: rtl/eth_mac_pkg.sv
// Shared types and PTP tag field helpers for the MAC TX arbiter.
// A tag is {sequence, port}: the port index sits in the LSBs, the sequence number fills the MSBs.
package eth_mac_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_t;

  localparam int unsigned TAG_MAX_WIDTH = 64;

  function automatic logic [TAG_MAX_WIDTH-1:0] port_mask(input int unsigned port_width);
    return (TAG_MAX_WIDTH'(1) << port_width) - TAG_MAX_WIDTH'(1);
  endfunction

  function automatic logic [TAG_MAX_WIDTH-1:0] tag_pack(
    input logic [TAG_MAX_WIDTH-1:0] seq,
    input logic [TAG_MAX_WIDTH-1:0] port,
    input int unsigned              port_width
  );
    return (seq << port_width) | (port & port_mask(port_width));
  endfunction

  function automatic logic [TAG_MAX_WIDTH-1:0] tag_port(
    input logic [TAG_MAX_WIDTH-1:0] tag,
    input int unsigned              port_width
  );
    return tag & port_mask(port_width);
  endfunction

endpackage

// File: rtl/eth_rr_arb.sv
// Combinational round-robin pick: first requesting port at or after ptr, wrapping modulo PORTS.
module eth_rr_arb #(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned PORT_WIDTH = $clog2(PORTS)
) (
  input  logic [PORTS-1:0]      req,
  input  logic [PORT_WIDTH-1:0] ptr,
  output logic [PORTS-1:0]      grant_oh_c,
  output logic [PORT_WIDTH-1:0] grant_idx_c,
  output logic                  grant_valid_c
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant_oh_c    = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    idx           = 0;
    found         = 1'b0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      idx = (32'(ptr) + i) % PORTS;
      if (!found && req[idx]) begin
        found            = 1'b1;
        grant_idx_c      = PORT_WIDTH'(idx);
        grant_oh_c[idx]  = 1'b1;
      end
    end
    grant_valid_c = found;
  end

endmodule

// File: rtl/eth_mac_tx_arb.sv
// Frame-granular round-robin arbiter in front of the MAC TX stream; tags each frame
// with {seq, port} and steers returned PTP timestamps back to the owning port.
module eth_mac_tx_arb
  import eth_mac_pkg::*;
#(
  parameter int unsigned PORTS           = 4,
  parameter int unsigned AXIS_DATA_WIDTH = 64,
  parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int unsigned PTP_TS_WIDTH    = 96,
  parameter int unsigned PTP_TAG_WIDTH   = 16
) (
  input  logic                               tx_clk,
  input  logic                               tx_rst,
  input  logic [PORTS*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS*AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [PORTS-1:0]                   s_axis_tlast,
  input  logic [PORTS-1:0]                   s_axis_tuser,
  input  logic [PORTS-1:0]                   s_axis_tvalid,
  output logic [PORTS-1:0]                   s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]         tx_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]         tx_axis_tkeep,
  output logic                               tx_axis_tlast,
  output logic [PTP_TAG_WIDTH:0]             tx_axis_tuser,
  output logic                               tx_axis_tvalid,
  input  logic                               tx_axis_tready,
  input  logic [PTP_TS_WIDTH-1:0]            tx_ptp_ts,
  input  logic [PTP_TAG_WIDTH-1:0]           tx_ptp_ts_tag,
  input  logic                               tx_ptp_ts_valid,
  output logic [PTP_TS_WIDTH-1:0]            port_ptp_ts,
  output logic [PTP_TAG_WIDTH-1:0]           port_ptp_ts_tag,
  output logic [PORTS-1:0]                   port_ptp_ts_valid
);

  localparam int unsigned PORT_WIDTH = $clog2(PORTS);
  localparam int unsigned SEQ_WIDTH  = PTP_TAG_WIDTH - PORT_WIDTH;

  arb_state_t               state;
  arb_state_t               state_next;
  logic [PORT_WIDTH-1:0]    grant;
  logic [PORTS-1:0]         grant_oh;
  logic [PORT_WIDTH-1:0]    rr_ptr;
  logic [SEQ_WIDTH-1:0]     seq;
  logic [PTP_TAG_WIDTH-1:0] tag;

  logic [PORTS-1:0]         arb_oh_c;
  logic [PORT_WIDTH-1:0]    arb_idx_c;
  logic                     arb_valid_c;
  logic                     frame_end_c;
  logic [PORT_WIDTH-1:0]    ts_port_c;

  eth_rr_arb #(
    .PORTS      (PORTS),
    .PORT_WIDTH (PORT_WIDTH)
  ) u_rr_arb (
    .req           (s_axis_tvalid),
    .ptr           (rr_ptr),
    .grant_oh_c    (arb_oh_c),
    .grant_idx_c   (arb_idx_c),
    .grant_valid_c (arb_valid_c)
  );

  // Grant/tag latch at arbitration, sequence and pointer advance on the last accepted beat.
  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_oh <= '0;
      rr_ptr   <= '0;
      seq      <= '0;
      tag      <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && arb_valid_c) begin
        grant    <= arb_idx_c;
        grant_oh <= arb_oh_c;
        tag      <= PTP_TAG_WIDTH'(tag_pack(TAG_MAX_WIDTH'(seq), TAG_MAX_WIDTH'(arb_idx_c),
                                            PORT_WIDTH));
      end
      if (frame_end_c) begin
        seq    <= seq + SEQ_WIDTH'(1);
        rr_ptr <= (32'(grant) == PORTS - 1) ? '0 : grant + PORT_WIDTH'(1);
      end
    end
  end

  // Next state plus the zero-latency data path from the granted port to the MAC.
  always_comb begin
    state_next     = state;
    frame_end_c    = 1'b0;
    s_axis_tready  = '0;
    tx_axis_tdata  = '0;
    tx_axis_tkeep  = '0;
    tx_axis_tlast  = 1'b0;
    tx_axis_tuser  = '0;
    tx_axis_tvalid = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid_c) state_next = ACTIVE;
      end
      ACTIVE: begin
        tx_axis_tdata  = s_axis_tdata[32'(grant)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        tx_axis_tkeep  = s_axis_tkeep[32'(grant)*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
        tx_axis_tlast  = s_axis_tlast[grant];
        tx_axis_tvalid = s_axis_tvalid[grant];
        tx_axis_tuser  = {tag, s_axis_tuser[grant]};
        s_axis_tready  = grant_oh & {PORTS{tx_axis_tready}};
        frame_end_c    = s_axis_tvalid[grant] && tx_axis_tready && s_axis_tlast[grant];
        if (frame_end_c) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ts_port_c = PORT_WIDTH'(tag_port(TAG_MAX_WIDTH'(tx_ptp_ts_tag), PORT_WIDTH));

  // Timestamp return path; tags naming a nonexistent port are dropped.
  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      port_ptp_ts       <= '0;
      port_ptp_ts_tag   <= '0;
      port_ptp_ts_valid <= '0;
    end else begin
      port_ptp_ts_valid <= '0;
      if (tx_ptp_ts_valid && (32'(ts_port_c) < PORTS)) begin
        port_ptp_ts       <= tx_ptp_ts;
        port_ptp_ts_tag   <= tx_ptp_ts_tag;
        port_ptp_ts_valid <= PORTS'(1) << ts_port_c;
      end
    end
  end

endmodule

// File: tb/tb_eth_mac_tx_arb.sv
// Directed bench for eth_mac_tx_arb: arbitration order, tagging, backpressure,
// sequence wrap, timestamp routing and reset behaviour.
module tb_eth_mac_tx_arb;

  logic         tx_clk = 1'b0;
  logic         tx_rst;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic [3:0]   s_tlast, s_tuser, s_tvalid, s_tready;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic         m_tlast, m_tvalid, m_tready;
  logic [16:0]  m_tuser;
  logic [95:0]  ts_in, p_ts;
  logic [15:0]  ts_tag_in, p_tag;
  logic         ts_valid_in;
  logic [3:0]   p_valid;

  logic [191:0] s3_tdata;
  logic [23:0]  s3_tkeep;
  logic [2:0]   s3_tlast, s3_tuser, s3_tvalid, s3_tready;
  logic [63:0]  m3_tdata;
  logic [7:0]   m3_tkeep;
  logic         m3_tlast, m3_tvalid;
  logic [16:0]  m3_tuser;
  logic [15:0]  ts3_tag_in, p3_tag;
  logic         ts3_valid_in;
  logic [95:0]  p3_ts;
  logic [2:0]   p3_valid;

  int vectors    = 0;
  int miscompares = 0;

  always #5 tx_clk = ~tx_clk;

  eth_mac_tx_arb u_dut (
    .tx_clk            (tx_clk),
    .tx_rst            (tx_rst),
    .s_axis_tdata      (s_tdata),
    .s_axis_tkeep      (s_tkeep),
    .s_axis_tlast      (s_tlast),
    .s_axis_tuser      (s_tuser),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready),
    .tx_axis_tdata     (m_tdata),
    .tx_axis_tkeep     (m_tkeep),
    .tx_axis_tlast     (m_tlast),
    .tx_axis_tuser     (m_tuser),
    .tx_axis_tvalid    (m_tvalid),
    .tx_axis_tready    (m_tready),
    .tx_ptp_ts         (ts_in),
    .tx_ptp_ts_tag     (ts_tag_in),
    .tx_ptp_ts_valid   (ts_valid_in),
    .port_ptp_ts       (p_ts),
    .port_ptp_ts_tag   (p_tag),
    .port_ptp_ts_valid (p_valid)
  );

  eth_mac_tx_arb #(.PORTS(3)) u_dut3 (
    .tx_clk            (tx_clk),
    .tx_rst            (tx_rst),
    .s_axis_tdata      (s3_tdata),
    .s_axis_tkeep      (s3_tkeep),
    .s_axis_tlast      (s3_tlast),
    .s_axis_tuser      (s3_tuser),
    .s_axis_tvalid     (s3_tvalid),
    .s_axis_tready     (s3_tready),
    .tx_axis_tdata     (m3_tdata),
    .tx_axis_tkeep     (m3_tkeep),
    .tx_axis_tlast     (m3_tlast),
    .tx_axis_tuser     (m3_tuser),
    .tx_axis_tvalid    (m3_tvalid),
    .tx_axis_tready    (1'b1),
    .tx_ptp_ts         (ts_in),
    .tx_ptp_ts_tag     (ts3_tag_in),
    .tx_ptp_ts_valid   (ts3_valid_in),
    .port_ptp_ts       (p3_ts),
    .port_ptp_ts_tag   (p3_tag),
    .port_ptp_ts_valid (p3_valid)
  );

  function automatic logic [63:0] beat(input int p, input int b);
    return 64'hD0D0_0000_0000_0000 | (64'(p) << 16) | 64'(b);
  endfunction

  function automatic logic [7:0] keepv(input int b);
    return 8'(8'hFF >> b);
  endfunction

  task automatic step();
    @(posedge tx_clk);
    @(negedge tx_clk);
  endtask

  task automatic drive(input int p, input logic v, input logic l, input int b);
    s_tvalid[p]          = v;
    s_tlast[p]           = l;
    s_tdata[p*64 +: 64]  = beat(p, b);
    s_tkeep[p*8 +: 8]    = keepv(b);
  endtask

  task automatic do_reset();
    tx_rst = 1'b1;
    step();
    tx_rst = 1'b0;
  endtask

  task automatic test_reset();
    tx_rst = 1'b1;
    repeat (2) step();
    #1;
    vectors++;
    if (m_tvalid !== 1'b0 || s_tready !== 4'b0000 || m_tuser !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_tx: tvalid=%b tready=%b tuser=%h expected 0/0000/00000", m_tvalid, s_tready, m_tuser);
    end
    vectors++;
    if (p_valid !== 4'b0000 || p_ts !== 96'h0 || p_tag !== 16'h0 || p3_valid !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ts: valid=%b ts=%h tag=%h v3=%b expected zeros", p_valid, p_ts, p_tag, p3_valid);
    end
    tx_rst = 1'b0;
  endtask

  task automatic test_single_frame();
    drive(0, 1'b1, 1'b0, 0);
    #1;
    vectors++;
    if (m_tvalid !== 1'b0 || s_tready !== 4'b0000) begin
      miscompares++;
      $display("FAIL arb_cycle: tvalid=%b tready=%b expected 0/0000", m_tvalid, s_tready);
    end
    step();
    for (int b = 0; b < 3; b++) begin
      drive(0, 1'b1, (b == 2), b);
      #1;
      vectors++;
      if (m_tvalid !== 1'b1 || m_tdata !== beat(0, b) || m_tkeep !== keepv(b) ||
          m_tlast !== (b == 2)) begin
        miscompares++;
        $display("FAIL single_beat%0d: v=%b d=%h k=%h l=%b expected 1 %h %h %b",
                 b, m_tvalid, m_tdata, m_tkeep, m_tlast, beat(0, b), keepv(b), (b == 2));
      end
      vectors++;
      if (m_tuser !== 17'h0 || s_tready !== 4'b0001) begin
        miscompares++;
        $display("FAIL single_tag%0d: tuser=%h tready=%b expected 00000 0001", b, m_tuser, s_tready);
      end
      step();
    end
    drive(0, 1'b0, 1'b0, 0);
    #1;
    vectors++;
    if (m_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end: tvalid=%b expected 0", m_tvalid);
    end
    drive(0, 1'b1, 1'b1, 5);
    step();
    #1;
    vectors++;
    if (m_tuser !== {16'h0004, 1'b0}) begin
      miscompares++;
      $display("FAIL seq_incr: tuser=%h expected %h", m_tuser, {16'h0004, 1'b0});
    end
    step();
    drive(0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_round_robin();
    logic [16:0] exp_user;
    int g;
    do_reset();
    for (int p = 0; p < 4; p++) drive(p, 1'b1, 1'b1, 0);
    s_tuser = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      g = k % 4;
      exp_user = {16'((k << 2) | g), (g == 2)};
      vectors++;
      if (m_tvalid !== 1'b1 || m_tdata !== beat(g, 0) || m_tuser !== exp_user ||
          s_tready !== 4'(1 << g)) begin
        miscompares++;
        $display("FAIL rr_frame%0d: v=%b d=%h tuser=%h tready=%b expected 1 %h %h %b",
                 k, m_tvalid, m_tdata, m_tuser, s_tready, beat(g, 0), exp_user, 4'(1 << g));
      end
      step();
      #1;
      vectors++;
      if (m_tvalid !== 1'b0 || s_tready !== 4'b0000) begin
        miscompares++;
        $display("FAIL rr_bubble%0d: tvalid=%b tready=%b expected 0/0000", k, m_tvalid, s_tready);
      end
    end
    for (int p = 0; p < 4; p++) drive(p, 1'b0, 1'b0, 0);
    s_tuser = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    int idx;
    pat = 6'b101001;
    idx = 0;
    do_reset();
    drive(2, 1'b1, 1'b0, 0);
    step();
    drive(0, 1'b1, 1'b1, 0);
    drive(3, 1'b1, 1'b1, 0);
    for (int c = 0; c < 6; c++) begin
      m_tready = pat[c];
      drive(2, 1'b1, (idx == 2), idx);
      #1;
      vectors++;
      if (m_tdata !== beat(2, idx) || m_tlast !== (idx == 2) || m_tuser !== {16'h0002, 1'b0} ||
          s_tready !== (pat[c] ? 4'b0100 : 4'b0000)) begin
        miscompares++;
        $display("FAIL stall_c%0d: d=%h l=%b tuser=%h tready=%b expected %h %b %h %b",
                 c, m_tdata, m_tlast, m_tuser, s_tready, beat(2, idx), (idx == 2),
                 {16'h0002, 1'b0}, (pat[c] ? 4'b0100 : 4'b0000));
      end
      step();
      if (pat[c]) idx++;
    end
    m_tready = 1'b1;
    drive(2, 1'b0, 1'b0, 0);
    #1;
    vectors++;
    if (m_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_end: tvalid=%b expected 0", m_tvalid);
    end
    step();
    #1;
    vectors++;
    if (m_tuser !== {16'h0007, 1'b0} || s_tready !== 4'b1000) begin
      miscompares++;
      $display("FAIL stall_next: tuser=%h tready=%b expected %h 1000", m_tuser, s_tready, {16'h0007, 1'b0});
    end
    step();
    drive(0, 1'b0, 1'b0, 0);
    drive(3, 1'b0, 1'b0, 0);
  endtask

  task automatic test_ts_route();
    ts_valid_in  = 1'b1;
    ts_in        = 96'h123;
    ts_tag_in    = 16'h0017;
    ts3_valid_in = 1'b1;
    ts3_tag_in   = 16'h0017;
    step();
    #1;
    vectors++;
    if (p_valid !== 4'b1000 || p_ts !== 96'h123 || p_tag !== 16'h0017) begin
      miscompares++;
      $display("FAIL ts_route: v=%b ts=%h tag=%h expected 1000 123 0017", p_valid, p_ts, p_tag);
    end
    vectors++;
    if (p3_valid !== 3'b000) begin
      miscompares++;
      $display("FAIL ts_discard: v3=%b expected 000", p3_valid);
    end
    ts_in      = 96'h456;
    ts_tag_in  = 16'h0021;
    ts3_tag_in = 16'h0002;
    step();
    #1;
    vectors++;
    if (p_valid !== 4'b0010 || p_ts !== 96'h456 || p_tag !== 16'h0021 || p3_valid !== 3'b100) begin
      miscompares++;
      $display("FAIL ts_b2b1: v=%b ts=%h tag=%h v3=%b expected 0010 456 0021 100", p_valid, p_ts, p_tag, p3_valid);
    end
    ts_in        = 96'h789;
    ts_tag_in    = 16'h0000;
    ts3_valid_in = 1'b0;
    step();
    #1;
    vectors++;
    if (p_valid !== 4'b0001 || p_ts !== 96'h789 || p3_valid !== 3'b000) begin
      miscompares++;
      $display("FAIL ts_b2b2: v=%b ts=%h v3=%b expected 0001 789 000", p_valid, p_ts, p3_valid);
    end
    ts_valid_in = 1'b0;
    step();
    #1;
    vectors++;
    if (p_valid !== 4'b0000 || p_ts !== 96'h789) begin
      miscompares++;
      $display("FAIL ts_idle: v=%b ts=%h expected 0000 789", p_valid, p_ts);
    end
  endtask

  task automatic test_seq_wrap();
    logic [16:0] exp_user;
    do_reset();
    drive(1, 1'b1, 1'b1, 0);
    for (int k = 0; k <= 16384; k++) begin
      step();
      #1;
      if (k < 2 || k >= 16383) begin
        exp_user = {16'(((k % 16384) << 2) | 1), 1'b0};
        vectors++;
        if (m_tvalid !== 1'b1 || m_tuser !== exp_user) begin
          miscompares++;
          $display("FAIL seq_wrap%0d: v=%b tuser=%h expected 1 %h", k, m_tvalid, m_tuser, exp_user);
        end
      end
      step();
    end
    drive(1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_frame();
    drive(1, 1'b1, 1'b0, 0);
    step();
    #1;
    vectors++;
    if (m_tuser !== {16'h0005, 1'b0} || s_tready !== 4'b0010) begin
      miscompares++;
      $display("FAIL midrst_pre: tuser=%h tready=%b expected %h 0010", m_tuser, s_tready, {16'h0005, 1'b0});
    end
    step();
    drive(1, 1'b1, 1'b0, 1);
    tx_rst = 1'b1;
    step();
    tx_rst = 1'b0;
    drive(1, 1'b0, 1'b0, 0);
    drive(3, 1'b1, 1'b1, 0);
    #1;
    vectors++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 64'h0 || m_tuser !== 17'h0 ||
        s_tready !== 4'b0000 || p_valid !== 4'b0000 || p_ts !== 96'h0) begin
      miscompares++;
      $display("FAIL midrst_out: v=%b l=%b d=%h tuser=%h tready=%b pv=%b ts=%h expected zeros",
               m_tvalid, m_tlast, m_tdata, m_tuser, s_tready, p_valid, p_ts);
    end
    step();
    #1;
    vectors++;
    if (m_tvalid !== 1'b1 || m_tuser !== {16'h0003, 1'b0} || s_tready !== 4'b1000) begin
      miscompares++;
      $display("FAIL midrst_grant: v=%b tuser=%h tready=%b expected 1 %h 1000",
               m_tvalid, m_tuser, s_tready, {16'h0003, 1'b0});
    end
    step();
    drive(3, 1'b0, 1'b0, 0);
    step();
  endtask

  initial begin
    tx_rst       = 1'b1;
    s_tdata      = '0;
    s_tkeep      = '0;
    s_tlast      = '0;
    s_tuser      = '0;
    s_tvalid     = '0;
    m_tready     = 1'b1;
    ts_in        = '0;
    ts_tag_in    = '0;
    ts_valid_in  = 1'b0;
    s3_tdata     = '0;
    s3_tkeep     = '0;
    s3_tlast     = '0;
    s3_tuser     = '0;
    s3_tvalid    = '0;
    ts3_tag_in   = '0;
    ts3_valid_in = 1'b0;
    @(negedge tx_clk);
    test_reset();
    test_single_frame();
    test_round_robin();
    test_back_to_back();
    test_ts_route();
    test_seq_wrap();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_mac_tx_arb.md
# eth_mac_tx_arb

Frame-granular round-robin arbiter that shares one Ethernet MAC transmit AXI-stream port among PORTS requesters. It tags every frame with a PTP tag encoding source port and sequence number, and routes timestamps returned by the MAC back to the originating port. It sits directly in front of the MAC TX interface in the tx_clk domain.

## Interface
- PORTS, 4: number of requester ports (2..16)
- AXIS_DATA_WIDTH, 64: stream data width
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8: tkeep width
- PTP_TS_WIDTH, 96: timestamp width
- PTP_TAG_WIDTH, 16: tag width; must exceed PORT_WIDTH
- PORT_WIDTH (derived), $clog2(PORTS): port field width
- SEQ_WIDTH (derived), PTP_TAG_WIDTH-PORT_WIDTH: sequence field width

Ports (s_* signals are flattened, port i at slice i):
- tx_clk  in  1  clock; the block's only clock
- tx_rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  PORTS*AXIS_DATA_WIDTH  per-port data
- s_axis_tkeep  in  PORTS*AXIS_KEEP_WIDTH  per-port keep
- s_axis_tlast  in  PORTS  per-port last
- s_axis_tuser  in  PORTS  per-port error bit
- s_axis_tvalid  in  PORTS  per-port valid
- s_axis_tready  out  PORTS  per-port ready
- tx_axis_tdata  out  AXIS_DATA_WIDTH  to MAC
- tx_axis_tkeep  out  AXIS_KEEP_WIDTH  to MAC
- tx_axis_tlast  out  1  to MAC
- tx_axis_tuser  out  PTP_TAG_WIDTH+1  {tag, error}
- tx_axis_tvalid  out  1  to MAC
- tx_axis_tready  in  1  from MAC
- tx_ptp_ts  in  PTP_TS_WIDTH  returned timestamp
- tx_ptp_ts_tag  in  PTP_TAG_WIDTH  returned tag
- tx_ptp_ts_valid  in  1  timestamp strobe
- port_ptp_ts  out  PTP_TS_WIDTH  routed timestamp (shared bus)
- port_ptp_ts_tag  out  PTP_TAG_WIDTH  routed tag (shared bus)
- port_ptp_ts_valid  out  PORTS  one-hot strobe to owning port

## Operation
- FSM states IDLE, ACTIVE.
- IDLE: all s_axis_tready=0, tx_axis_tvalid=0. If any s_axis_tvalid, grant the first requesting port at or after rr_ptr (wrapping modulo PORTS), latch grant, latch tag={seq, grant}, go to ACTIVE.
- ACTIVE: tx_axis_{tdata,tkeep,tlast,tvalid} = granted slice; tx_axis_tuser={tag, s_axis_tuser[grant]}; s_axis_tready[grant]=tx_axis_tready, other readies 0. Tag constant for the whole frame.
- Beat accepted with tlast in ACTIVE: seq <= seq+1 (wraps at 2^SEQ_WIDTH), rr_ptr <= grant+1 (grant=PORTS-1 wraps to 0), go to IDLE.
- No mid-frame preemption; a port holding tvalid low mid-frame stalls the MAC port.
- Timestamp return: on tx_ptp_ts_valid, p = tx_ptp_ts_tag[PORT_WIDTH-1:0]; register ts and tag, assert port_ptp_ts_valid[p] for one cycle. p>=PORTS: discard, no strobe. Independent of FSM; back-to-back strobes each produce one output strobe.
- Reset: state IDLE, rr_ptr=0, seq=0, all outputs 0 incl. port_ptp_ts, port_ptp_ts_tag, port_ptp_ts_valid. Reset mid-frame truncates the frame to the MAC without tlast; that is the required behaviour.

## Timing
- Arbitration: 1 cycle; first beat on tx_axis the cycle after entering ACTIVE.
- Data path combinational from granted port to MAC in ACTIVE (zero latency).
- One bubble cycle (IDLE) between frames, also when the same port re-requests.
- Timestamp routing latency: 1 cycle, tx_ptp_ts_valid at edge N -> port_ptp_ts_valid at edge N+1.
- Single-beat frame (tlast on first beat): ACTIVE exactly 1 cycle if tx_axis_tready=1.

## Structure
- Shared package eth_mac_pkg: state enum (IDLE, ACTIVE), tag field layout helpers (port field LSBs, sequence MSBs) used by both tag generation and decode.
- Natural sub-module: eth_rr_arb (PORTS-wide request vector, pointer in, one-hot/index grant out; combinational priority rotate). Rest in top.

## Test plan
- Single port 0 sends 3-beat frame, tready=1 -> tx_axis_tuser tag=0x0000 on all 3 beats, tlast on beat 3, seq becomes 1.
- Ports 0..3 all request continuously, 1-beat frames -> grant order 0,1,2,3,0; tags {0,0},{1,1},{2,2},{3,3},{4,0}; one idle cycle between frames.
- tx_axis_tready toggled 1/0 during port 2 frame -> no beats lost or duplicated, other ports' tready stay 0, tag unchanged across stall.
- tx_ptp_ts_valid with tag {5,3}, ts=0x123 -> next cycle port_ptp_ts_valid=4'b1000, port_ptp_ts=0x123; PORTS=3 with tag port field 3 -> no strobe.
- Run 2^SEQ_WIDTH+1 frames -> sequence field wraps to 0, port field correct.
- Assert tx_rst mid-frame on port 1 -> next cycle all outputs 0, IDLE; subsequent request from port 3 gets tag 0x0003 granted first (rr_ptr=0 scan reaches 3).
